// File: rtl/path_tracer.sv
// path_tracer: walks a cursor over a 16x16 grid, one cell per accepted move.
// A trace begins on a start pulse at (0,0). Every cell the cursor occupies,
// including the origin, is offered downstream on the pos channel. Moves are
// then taken one at a time from the move channel. The trace ends in DONE
// when the cursor reaches (15,15). It ends in ERR on a move off the grid,
// on step-count saturation, or when the final flagged move is emitted
// without reaching (15,15).
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle pulse; honoured in IDLE, DONE and ERR
//   move_valid/move/    move channel (00 X-1, 01 Y+1, 10 Y-1, 11 X+1),
//   move_last/move_ready  move_last marks the final move of a trace
//   pos_x/pos_y/        coordinate channel; pos_x/pos_y always show the
//   pos_valid/pos_ready   current cell
//   step_count          moves applied in this trace (saturates at 255)
//   busy/done/error     status flags
//   state_dbg           current FSM state, for observation only
//
// Handshake: each channel transfers on a rising edge where valid and ready
// are both 1. The producer holds valid and payload stable until that edge.
// move_ready never depends on move_valid. pos_valid never depends on
// pos_ready.
module path_tracer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move,
  input  logic       move_last,
  output logic       move_ready,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       pos_valid,
  input  logic       pos_ready,
  output logic [7:0] step_count,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EMIT    = 3'd1,
    S_WAIT_MV = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [3:0] cur_x, cur_y;
  logic [7:0] steps;
  logic       last_q;

  logic [3:0] nx, ny;
  logic       off_grid;
  logic       can_start;
  logic       move_acc;
  logic       move_ok;
  logic       at_goal;

  // Start is honoured only from the resting states.
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign move_acc  = (state == S_WAIT_MV) && move_valid;
  // A move applies only when it stays on the grid and the counter has room.
  assign move_ok   = !off_grid && (steps != 8'd255);
  assign at_goal   = (cur_x == 4'd15) && (cur_y == 4'd15);

  // Candidate cell for the offered move, plus the edge-of-grid check.
  always_comb begin
    nx       = cur_x;
    ny       = cur_y;
    off_grid = 1'b0;
    case (move)
      2'b00: begin off_grid = (cur_x == 4'd0);  nx = cur_x - 4'd1; end
      2'b01: begin off_grid = (cur_y == 4'd15); ny = cur_y + 4'd1; end
      2'b10: begin off_grid = (cur_y == 4'd0);  ny = cur_y - 4'd1; end
      2'b11: begin off_grid = (cur_x == 4'd15); nx = cur_x + 4'd1; end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_EMIT;
      end
      S_EMIT: begin
        if (pos_ready) begin
          // Reaching the goal wins over a flagged final move.
          if (at_goal)     state_next = S_DONE;
          else if (last_q) state_next = S_ERR;
          else             state_next = S_WAIT_MV;
        end
      end
      S_WAIT_MV: begin
        if (move_valid) state_next = move_ok ? S_EMIT : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Cursor, step counter and last-move flag. Rejected moves leave all of
  // them untouched, so ERR reports the cell where the trace stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_x  <= 4'd0;
      cur_y  <= 4'd0;
      steps  <= 8'd0;
      last_q <= 1'b0;
    end else if (start && can_start) begin
      cur_x  <= 4'd0;
      cur_y  <= 4'd0;
      steps  <= 8'd0;
      last_q <= 1'b0;
    end else if (move_acc && move_ok) begin
      cur_x  <= nx;
      cur_y  <= ny;
      steps  <= steps + 8'd1;
      last_q <= move_last;
    end
  end

  // Outputs depend on state alone, so reset clears them in the same cycle.
  always_comb begin
    move_ready = (state == S_WAIT_MV);
    pos_valid  = (state == S_EMIT);
    busy       = (state == S_EMIT) || (state == S_WAIT_MV);
    done       = (state == S_DONE);
    error      = (state == S_ERR);
    pos_x      = cur_x;
    pos_y      = cur_y;
    step_count = steps;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_path_tracer.sv
// Bench for path_tracer. A move list is turned into the list of cells and
// the final outcome by a plain grid-walk model. The expected cells are
// queued, and a separate monitor compares every accepted coordinate.
module tb_path_tracer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move = 2'b00;
  logic       move_last = 1'b0;
  logic       move_ready;
  logic [3:0] pos_x, pos_y;
  logic       pos_valid;
  logic       pos_ready = 1'b1;
  logic [7:0] step_count;
  logic       busy, done, error;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;   // 0: pos_ready high, 1: random, 2: driven directly

  logic [7:0] exp_q[$];
  logic [1:0] mv[$];
  bit         lst[$];

  path_tracer dut (
    .clk(clk), .rst(rst), .start(start),
    .move_valid(move_valid), .move(move), .move_last(move_last),
    .move_ready(move_ready),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .step_count(step_count), .busy(busy), .done(done), .error(error),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out @%0t", name, $time);
  endtask

  // ---------------- downstream ready driver ----------------
  always @(negedge clk) begin
    if (rdy_mode == 0)      pos_ready = 1'b1;
    else if (rdy_mode == 1) pos_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && pos_valid && pos_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pos_unexpected actual=(%0d,%0d) expected=none", pos_x, pos_y);
        end else begin
          e = exp_q.pop_front();
          chk("pos", int'({pos_x, pos_y}), int'(e));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Walks the move list over the grid and queues every cell that will be
  // emitted. Returns the number of moves the block will accept and the
  // final outcome.
  task automatic model(output int n_acc, output bit e_done, output bit e_err,
                       output int e_steps, output int e_x, output int e_y);
    int x, y, s, nx, ny;
    x = 0; y = 0; s = 0;
    n_acc = 0; e_done = 0; e_err = 0;
    exp_q.push_back(8'h00);
    foreach (mv[i]) begin
      nx = x; ny = y;
      case (mv[i])
        2'd0: nx = x - 1;
        2'd1: ny = y + 1;
        2'd2: ny = y - 1;
        default: nx = x + 1;
      endcase
      n_acc++;
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15 || s == 255) begin
        e_err = 1;
        break;
      end
      x = nx; y = ny; s++;
      exp_q.push_back({x[3:0], y[3:0]});
      if (x == 15 && y == 15) begin e_done = 1; break; end
      if (lst[i]) begin e_err = 1; break; end
    end
    e_steps = s; e_x = x; e_y = y;
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Offers one move with random valid gaps until it is accepted. While the
  // block is busy, stray start pulses are thrown in; they must be ignored.
  task automatic offer_move(input logic [1:0] m, input logic l, output bit ok);
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      start      = busy && ($urandom_range(0, 7) == 0);
      move_valid = ($urandom_range(0, 3) != 0);
      move       = move_valid ? m : 2'($urandom_range(0, 3));
      move_last  = move_valid ? l : 1'($urandom_range(0, 1));
      #1;
      if (move_valid && move_ready) ok = 1;
    end
    @(negedge clk);
    start = 1'b0;
    move_valid = 1'b0;
    move = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (!busy) ok = 1;
    end
  endtask

  task automatic run_trace(input string tag);
    int n, es, ex, ey;
    bit ed, ee, ok;
    model(n, ed, ee, es, ex, ey);
    pulse_start();
    for (int i = 0; i < n; i++) begin
      offer_move(mv[i], lst[i], ok);
      if (!ok) begin fail_now({tag, "_move_accept"}); break; end
    end
    wait_idle(ok);
    if (!ok) fail_now({tag, "_idle"});
    chk({tag, "_done"},       int'(done),       int'(ed));
    chk({tag, "_error"},      int'(error),      int'(ee));
    chk({tag, "_step_count"}, int'(step_count), es);
    chk({tag, "_pos_x"},      int'(pos_x),      ex);
    chk({tag, "_pos_y"},      int'(pos_y),      ey);
    chk({tag, "_move_ready"}, int'(move_ready), 0);
    chk({tag, "_pending"},    exp_q.size(),     0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},       int'(busy),       0);
    chk({tag, "_done"},       int'(done),       0);
    chk({tag, "_error"},      int'(error),      0);
    chk({tag, "_pos_valid"},  int'(pos_valid),  0);
    chk({tag, "_move_ready"}, int'(move_ready), 0);
    chk({tag, "_step_count"}, int'(step_count), 0);
    chk({tag, "_pos"},        int'({pos_x, pos_y}), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int len, r;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_release_busy", int'(busy), 0);
    chk("idle_after_release_pos_valid", int'(pos_valid), 0);

    // Happy path: 15 x (X+1), 15 x (Y+1), last flagged
    mv.delete(); lst.delete();
    for (int i = 0; i < 15; i++) begin mv.push_back(2'd3); lst.push_back(0); end
    for (int i = 0; i < 15; i++) begin mv.push_back(2'd1); lst.push_back(i == 14); end
    run_trace("happy");

    // Off the grid at the origin
    mv.delete(); lst.delete();
    mv.push_back(2'd0); lst.push_back(0);
    run_trace("boundary");

    // Flagged final move short of the goal
    mv.delete(); lst.delete();
    mv.push_back(2'd3); lst.push_back(1);
    run_trace("early_last");

    // Back-pressure while (1,0) is offered
    rdy_mode = 2; pos_ready = 1'b1;
    mv.delete(); lst.delete();
    mv.push_back(2'd3); lst.push_back(0);
    mv.push_back(2'd3); lst.push_back(1);
    fork
      run_trace("bp");
      begin
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
          @(negedge clk);
          if (pos_valid && pos_x == 4'd1 && pos_y == 4'd0) begin
            ok = 1;
            pos_ready = 1'b0;
          end
        end
        if (!ok) fail_now("bp_find_emit");
        repeat (5) begin
          @(negedge clk);
          #1;
          chk("bp_pos_valid", int'(pos_valid), 1);
          chk("bp_pos", int'({pos_x, pos_y}), 8'h10);
          chk("bp_move_ready", int'(move_ready), 0);
        end
        pos_ready = 1'b1;
      end
    join
    rdy_mode = 1;

    // Reset while waiting for a move at (3,2) with five steps taken
    mv.delete(); lst.delete();
    mv = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1};
    lst = '{0, 0, 0, 0, 0, 0};
    begin
      int n, es, ex, ey;
      bit ed, ee;
      model(n, ed, ee, es, ex, ey);
    end
    // Only the origin and the first five moves get emitted before reset.
    void'(exp_q.pop_back());
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      offer_move(mv[i], lst[i], ok);
      if (!ok) begin fail_now("rst_mid_move_accept"); break; end
    end
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (move_ready) ok = 1;
    end
    if (!ok) fail_now("rst_mid_wait_mv");
    chk("rst_mid_pre_steps", int'(step_count), 5);
    chk("rst_mid_pre_pos", int'({pos_x, pos_y}), 8'h32);
    chk("rst_mid_emitted", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk); rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_mid_idle_busy", int'(busy), 0);
      chk("rst_mid_idle_pos_valid", int'(pos_valid), 0);
    end
    mv.delete(); lst.delete();
    mv.push_back(2'd1); lst.push_back(1);
    run_trace("after_rst");

    // Saturation: 256 alternating X+1 / X-1 moves
    mv.delete(); lst.delete();
    for (int i = 0; i < 256; i++) begin
      mv.push_back((i % 2 == 0) ? 2'd3 : 2'd0);
      lst.push_back(0);
    end
    run_trace("saturate");

    // Random walks, biased toward the goal, last move always flagged
    for (int t = 0; t < 25; t++) begin
      mv.delete(); lst.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        mv.push_back(r < 4 ? 2'd3 : r < 8 ? 2'd1 : r < 9 ? 2'd0 : 2'd2);
        lst.push_back(i == len - 1);
      end
      run_trace("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
